matrix_mult_seq: RTL and testbench
==================================

MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

Interface
REQ-001 Parameter DW, default 20, SHALL be the element width: signed two's complement.
REQ-002 Parameter N, default 5, SHALL be the matrix order (N x N).
REQ-003 Parameter ACC_W, default 2*DW+3 (43), SHALL be the product element width.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port s_valid, input, 1 bit: the input beat on s_data is valid.
REQ-007 Port s_ready, output, 1 bit: the block accepts an input beat.
REQ-008 Port s_data, input, DW bits: one matrix element per beat.
REQ-009 Port s_last, input, 1 bit: marks the final beat of a frame.
REQ-010 Port m_valid, output, 1 bit: m_data holds a product element.
REQ-011 Port m_ready, input, 1 bit: the downstream block accepts the element.
REQ-012 Port m_data, output, ACC_W bits: one element C[i][j] of C = A*B.
REQ-013 Port m_last, output, 1 bit: asserted with element C[N][N].
REQ-014 Port err, output, 1 bit: one-cycle pulse on a framing error.
REQ-015 Port diag_ok, output, 1 bit: diagonal-check result; see Configuration.

Function
REQ-016 The input frame SHALL be 2*N*N beats: A in row-major order, then B in row-major order.
REQ-017 A beat SHALL transfer only on a cycle where s_valid and s_ready are both 1.
REQ-018 The state machine SHALL have three states: LOAD, MAC and EMIT.
REQ-019 LOAD: s_ready is 1, and each accepted beat is stored in the A or B register array at beat counter k, after which k increments.
REQ-020 On the beat with k = 2*N*N-1 and s_last = 1, the block SHALL go to MAC with i=j=1, and s_ready SHALL be 0 from the next cycle.
REQ-021 If s_last = 1 on any earlier beat, the block SHALL pulse err, set k to 0 and stay in LOAD.
REQ-022 If s_last = 0 on beat 2*N*N-1, the block SHALL pulse err, set k to 0 and stay in LOAD.
REQ-023 In both error cases the stored frame SHALL be discarded.
REQ-024 MAC: the accumulator SHALL clear at entry, then add sign-extended A[i][t]*B[t][j] for t = 1..N, one term per cycle, N cycles in total.
REQ-025 Arithmetic SHALL be full-precision signed at ACC_W bits, so that overflow is impossible for any inputs.
REQ-026 The block SHALL enter EMIT after the N-th MAC cycle, and m_data and m_valid SHALL be registered.
REQ-027 EMIT: m_valid = 1, and m_data and m_last SHALL hold stable until m_ready = 1.
REQ-028 On an EMIT handshake, the block SHALL advance j (then i), return to MAC, and drop m_valid for at least the N MAC cycles.
REQ-029 On an EMIT handshake for C[N][N] (m_last = 1), the block SHALL return to LOAD with k = 0.
REQ-030 Timing: the first m_valid SHALL occur N+1 cycles after the last input beat is accepted.
REQ-031 Throughput: with m_ready held at 1, the block SHALL take N*N*(N+1) cycles per frame.
REQ-032 m_ready SHALL be ignored outside EMIT, and s_valid SHALL be ignored outside LOAD.

Reset
REQ-033 Asserting rst_n = 0 SHALL put the block in LOAD with k = 0, i = j = 1 and the accumulator at 0.
REQ-034 During reset, s_ready = 1 after release, and m_valid, m_data, m_last, err and diag_ok SHALL all be 0.
REQ-035 Reset asserted during MAC or EMIT SHALL abort the frame: no partial output after release, and new frames load cleanly.
REQ-036 The A and B arrays SHALL need no reset.

Configuration
REQ-037 Macro MATRIX_DIAG_CHECK_EN defined: diag_ok SHALL be valid with the m_last beat.
REQ-038 With the macro defined, diag_ok SHALL be 1 only if every off-diagonal C element is 0 and all diagonal elements are equal and nonzero.
REQ-039 With the macro defined, diag_ok SHALL be cleared at the start of each frame's MAC phase.
REQ-040 Macro undefined: diag_ok SHALL be tied to 0 and no compare logic SHALL exist.

Structure
REQ-041 Shared package mat_pkg SHALL hold DW, N, ACC_W, the element and accumulator typedefs, and the state enum (LOAD, MAC, EMIT).
REQ-042 One sub-module, mat_mac, SHALL provide the signed multiply-accumulate with clear and enable.

Verification
REQ-043 Scenario: A = I, B = I, m_ready = 1 -> 25 outputs forming I, m_last on the 25th, diag_ok = 1 (if enabled), first m_valid 6 cycles after the last beat.
REQ-044 Scenario: A = 2I, B = -3I -> diagonal elements -6, others 0, diag_ok = 1.
REQ-045 Scenario: A and B all -524288 -> every C element = 5*2^38 with no wrap, and diag_ok = 0.
REQ-046 Scenario: m_ready low for 10 cycles on C[2][3] -> m_valid, m_data and m_last stay stable, with no skipped or duplicated element.
REQ-047 Scenario: s_last on beat 10 -> err pulses 1 cycle, then a full valid frame produces correct C.
REQ-048 Scenario: rst_n low during MAC of C[3][1] -> outputs go to 0 immediately, then the next frame produces 25 correct elements.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the sequential N x N signed matrix multiplier.
package mat_pkg;

    localparam int DW    = 20;
    localparam int N     = 5;
    localparam int ACC_W = 2*DW + 3;

    typedef logic signed [DW-1:0]    elem_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

endpackage

// File: rtl/mat_mac.sv
// Signed multiply-accumulate: sum = acc + a*b, with synchronous clear and enable.
module mat_mac #(
    parameter int DW    = 20,
    parameter int ACC_W = 2*DW + 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [2*DW-1:0]  p;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc;

    // Exact 2*DW product, then sign-extended into the guard bits
    assign p    = a * b;
    assign prod = {{(ACC_W-2*DW){p[2*DW-1]}}, p};
    assign sum  = acc + prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= sum;
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Streams in A then B (row-major), emits C = A*B one element at a time.
// Optional diagonal check enabled by defining MATRIX_DIAG_CHECK_EN.
module matrix_mult_seq
    import mat_pkg::*;
#(
    parameter int DW    = mat_pkg::DW,
    parameter int N     = mat_pkg::N,
    parameter int ACC_W = 2*DW + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data,
    output logic             m_last,
    output logic             err,
    output logic             diag_ok
);

    localparam int NN    = N*N;
    localparam int FRAME = 2*NN;
    localparam int KW    = $clog2(FRAME);
    localparam int AW    = $clog2(NN);
    localparam int IW    = (N > 1) ? $clog2(N) : 1;

    state_t state, state_nxt;

    // Row/column/term indices are kept 0-based internally
    logic [KW-1:0] k;
    logic [IW-1:0] i, j, t;
    logic signed [DW-1:0] a_mem [NN];
    logic signed [DW-1:0] b_mem [NN];
    logic [AW-1:0] a_idx, b_idx;
    logic beat, load_done, frame_err, mac_last, emit_hs, last_elem;
    logic signed [ACC_W-1:0] sum;

    assign s_ready   = (state == LOAD);
    assign last_elem = (i == IW'(N-1)) && (j == IW'(N-1));
    assign a_idx     = AW'(int'(i) * N + int'(t));
    assign b_idx     = AW'(int'(t) * N + int'(j));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        beat      = 1'b0;
        load_done = 1'b0;
        frame_err = 1'b0;
        mac_last  = 1'b0;
        emit_hs   = 1'b0;
        case (state)
            LOAD: if (s_valid) begin
                beat = 1'b1;
                if (k == KW'(FRAME-1)) begin
                    if (s_last) begin
                        load_done = 1'b1;
                        state_nxt = MAC;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else if (s_last) begin
                    frame_err = 1'b1;
                end
            end
            MAC: if (t == IW'(N-1)) begin
                mac_last  = 1'b1;
                state_nxt = EMIT;
            end
            EMIT: if (m_ready) begin
                emit_hs   = 1'b1;
                state_nxt = m_last ? LOAD : MAC;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Frame storage; a bad frame is simply overwritten by the next one
    always_ff @(posedge clk) begin
        if (beat) begin
            if (k < KW'(NN)) a_mem[AW'(k)]              <= s_data;
            else             b_mem[AW'(int'(k) - NN)]   <= s_data;
        end
    end

    mat_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_done | emit_hs),
        .en    (state == MAC),
        .a     (a_mem[a_idx]),
        .b     (b_mem[b_idx]),
        .sum   (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            i       <= '0;
            j       <= '0;
            t       <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= frame_err;
            if (beat) k <= (frame_err || load_done) ? '0 : k + 1'b1;
            if (load_done) begin
                i <= '0;
                j <= '0;
                t <= '0;
            end
            if (state == MAC) t <= mac_last ? '0 : t + 1'b1;
            // Final term is folded in here so EMIT starts right after N MAC cycles
            if (mac_last) begin
                m_valid <= 1'b1;
                m_data  <= sum;
                m_last  <= last_elem;
            end
            if (emit_hs) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                if (j == IW'(N-1)) begin
                    j <= '0;
                    i <= last_elem ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

`ifdef MATRIX_DIAG_CHECK_EN
    logic signed [ACC_W-1:0] diag_ref;
    logic diag_run, diag_q, elem_ok;

    always_comb begin
        if (i != j) elem_ok = (sum == '0);
        else        elem_ok = (sum != '0) && ((i == '0) || (sum == diag_ref));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diag_ref <= '0;
            diag_run <= 1'b0;
            diag_q   <= 1'b0;
        end else if (load_done) begin
            diag_run <= 1'b1;
            diag_q   <= 1'b0;
        end else if (mac_last) begin
            if (i == '0 && j == '0) diag_ref <= sum;
            diag_run <= diag_run & elem_ok;
            if (last_elem) diag_q <= diag_run & elem_ok;
        end
    end

    assign diag_ok = diag_q;
`else
    assign diag_ok = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Randomized bench for matrix_mult_seq against a plain-arithmetic matrix product model.
module tb_matrix_mult_seq;
    import mat_pkg::*;

    localparam int NN = N*N;

    logic clk = 1'b0, rst_n = 1'b0;
    logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready, m_valid, m_last, err, diag_ok;
    logic [ACC_W-1:0] m_data;

    int vecs = 0, miss = 0, cyc = 0, t_last = 0;
    longint a_m[NN], b_m[NN], c_m[NN];
    bit diag_exp;

    matrix_mult_seq dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .err(err), .diag_ok(diag_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic build_c();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                longint s = 0;
                for (int x = 0; x < N; x++) s += a_m[r*N+x] * b_m[x*N+c];
                c_m[r*N+c] = s;
            end
        diag_exp = (c_m[0] != 0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (r != c && c_m[r*N+c] != 0) diag_exp = 0;
                if (r == c && c_m[r*N+c] != c_m[0]) diag_exp = 0;
            end
`ifndef MATRIX_DIAG_CHECK_EN
        diag_exp = 0;
`endif
    endtask

    task automatic fill_scaled(input longint sa, input longint sb);
        for (int x = 0; x < NN; x++) begin
            a_m[x] = (x / N == x % N) ? sa : 0;
            b_m[x] = (x / N == x % N) ? sb : 0;
        end
        build_c();
    endtask

    task automatic fill_const(input longint v);
        for (int x = 0; x < NN; x++) begin a_m[x] = v; b_m[x] = v; end
        build_c();
    endtask

    task automatic fill_rand();
        int h = 1 << (DW-1);
        for (int x = 0; x < NN; x++) begin
            a_m[x] = longint'(int'($urandom_range(0, 2*h-1)) - h);
            b_m[x] = longint'(int'($urandom_range(0, 2*h-1)) - h);
        end
        build_c();
    endtask

    // Drives cnt beats; s_last on the final one if last_on_end. Returns at the negedge after it.
    task automatic send_beats(input int cnt, input bit last_on_end, input bit gaps);
        for (int b = 0; b < cnt; b++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = DW'(b < NN ? a_m[b] : b_m[b-NN]);
            s_last  = last_on_end && (b == cnt-1);
            vecs++;
            if (s_ready !== 1'b1 || err !== 1'b0) begin
                miss++;
                $display("FAIL load beat %0d: s_ready=%b err=%b, need 1/0", b, s_ready, err);
            end
        end
        t_last = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        send_beats(2*NN, 1'b1, gaps);
        vecs++;
        if (s_ready !== 1'b0 || err !== 1'b0) begin
            miss++;
            $display("FAIL frame end: s_ready=%b err=%b, need 0/0", s_ready, err);
        end
    endtask

    task automatic collect(input int stall_e, input bit rand_ready);
        int e = 0, guard = 0, held = 0, t_first = 0;
        bit seen = 0;
        while (e < NN && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (m_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1; t_first = cyc; vecs++;
                    if (cyc - t_last != N+1) begin
                        miss++;
                        $display("FAIL latency: got %0d cycles, need %0d", cyc - t_last, N+1);
                    end
                end
                vecs++;
                if (m_data !== ACC_W'(c_m[e]) || m_last !== (e == NN-1)) begin
                    miss++;
                    $display("FAIL elem %0d: got data=%0d last=%b, need data=%0d last=%b",
                             e, $signed(m_data), m_last, c_m[e], e == NN-1);
                end
                if (e == NN-1) begin
                    vecs++;
                    if (diag_ok !== diag_exp) begin
                        miss++;
                        $display("FAIL diag_ok: got %b, need %b", diag_ok, diag_exp);
                    end
                end
                if (e == stall_e && held < 10) begin m_ready = 1'b0; held++; end
                else if (rand_ready) m_ready = ($urandom_range(0, 2) != 0);
                else m_ready = 1'b1;
                if (m_ready) begin
                    if (e == NN-1 && stall_e < 0 && !rand_ready) begin
                        vecs++;
                        if (cyc - t_first != (NN-1)*(N+1)) begin
                            miss++;
                            $display("FAIL throughput: got %0d, need %0d", cyc - t_first, (NN-1)*(N+1));
                        end
                    end
                    e++;
                end
            end else begin
                m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        vecs++;
        if (e < NN) begin
            miss++;
            $display("FAIL collect timeout: got %0d elements, need %0d", e, NN);
        end
        @(negedge clk);
        m_ready = 1'b0;
        vecs++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            miss++;
            $display("FAIL after frame: m_valid=%b s_ready=%b, need 0/1", m_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({m_valid, m_last, err, diag_ok, m_data} !== '0) begin
            miss++;
            $display("FAIL reset outputs: got v=%b l=%b e=%b d=%b data=%0d, need all 0",
                     m_valid, m_last, err, diag_ok, m_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (s_ready !== 1'b1) begin
            miss++;
            $display("FAIL reset s_ready: got %b, need 1", s_ready);
        end
    endtask

    task automatic test_identity();
        fill_scaled(1, 1);  send_frame(1'b0); collect(-1, 1'b0);
        fill_scaled(2, -3); send_frame(1'b0); collect(-1, 1'b0);
    endtask

    task automatic test_extreme();
        fill_const(-longint'(1 << (DW-1)));
        send_frame(1'b0);
        collect(-1, 1'b0);
    endtask

    task automatic test_stall();
        fill_rand();
        send_frame(1'b0);
        collect(1*N + 2, 1'b0);
    endtask

    task automatic test_framing();
        for (int pass = 0; pass < 2; pass++) begin
            fill_rand();
            if (pass == 0) send_beats(10, 1'b1, 1'b0);
            else           send_beats(2*NN, 1'b0, 1'b0);
            vecs++;
            if (err !== 1'b1) begin
                miss++;
                $display("FAIL err pulse %0d: got %b, need 1", pass, err);
            end
            @(negedge clk);
            vecs++;
            if (err !== 1'b0 || s_ready !== 1'b1) begin
                miss++;
                $display("FAIL err end %0d: err=%b s_ready=%b, need 0/1", pass, err, s_ready);
            end
            fill_rand();
            send_frame(1'b0);
            collect(-1, 1'b0);
        end
    endtask

    task automatic test_abort();
        int e = 0, guard = 0;
        bit leaked = 0;
        fill_rand();
        send_frame(1'b0);
        while (e < 2*N && guard < 1000) begin
            @(negedge clk);
            guard++;
            m_ready = 1'b1;
            if (m_valid === 1'b1) begin
                vecs++;
                if (m_data !== ACC_W'(c_m[e])) begin
                    miss++;
                    $display("FAIL abort elem %0d: got %0d, need %0d", e, $signed(m_data), c_m[e]);
                end
                e++;
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({m_valid, m_last, err, m_data} !== '0 || e != 2*N) begin
            miss++;
            $display("FAIL abort reset: got v=%b data=%0d after %0d elems, need 0/0 after %0d",
                     m_valid, m_data, e, 2*N);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3*N*(N+1)) begin
            @(negedge clk);
            if (m_valid !== 1'b0) leaked = 1;
        end
        vecs++;
        if (leaked) begin
            miss++;
            $display("FAIL abort leak: got m_valid after reset, need none");
        end
        m_ready = 1'b0;
        fill_rand();
        send_frame(1'b0);
        collect(-1, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            fill_rand();
            send_frame(1'b1);
            collect(-1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_extreme();
        test_stall();
        test_framing();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
